// File: rtl/prog_mux_pkg.sv
// Shared constants for the programmable mux function: code encoding, FSM states, decode helper.
package prog_mux_pkg;

    localparam int unsigned CODE_W = 2;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CODE_ZERO = 2'b00;
    localparam code_t CODE_ONE  = 2'b01;
    localparam code_t CODE_D    = 2'b10;
    localparam code_t CODE_ND   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    function automatic logic decode(input code_t code, input logic d);
        logic r;
        case (code)
            CODE_ZERO: r = 1'b0;
            CODE_ONE:  r = 1'b1;
            CODE_D:    r = d;
            default:   r = ~d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/prog_mux_fn_if.sv
// Config/evaluate bus of prog_mux_fn; the master drives config and operands, the slave returns results.
interface prog_mux_fn_if #(
    parameter int unsigned SEL_W = 3
);
    logic             cfg_start;
    logic             cfg_valid;
    logic [1:0]       cfg_data;
    logic [SEL_W-1:0] s;
    logic             d;
    logic             in_valid;
    logic             f;
    logic             f_valid;
    logic             busy;
    logic             cfg_done;

    modport master (
        output cfg_start, cfg_valid, cfg_data, s, d, in_valid,
        input  f, f_valid, busy, cfg_done
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, s, d, in_valid,
        output f, f_valid, busy, cfg_done
    );
endinterface

// File: rtl/lut_table.sv
// N x 2-bit code storage: one write port, one combinational read port, synchronous clear.
module lut_table
    import prog_mux_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [SEL_W-1:0] waddr_i,
    input  code_t            wdata_i,
    input  logic [SEL_W-1:0] raddr_i,
    output code_t            rdata_o
);
    localparam int unsigned N = 2 ** SEL_W;

    code_t mem_q [N];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < int'(N); i++) begin
                mem_q[i] <= CODE_ZERO;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mux_fn.sv
// Programmable single-output function: a loaded code table selected by s, applied to residual d.
module prog_mux_fn
    import prog_mux_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input logic          clk,
    input logic          reset,
    prog_mux_fn_if.slave bus
);
    localparam int unsigned N     = 2 ** SEL_W;
    localparam int unsigned IDX_W = SEL_W + 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             f_q, f_d;
    logic             f_valid_q, f_valid_d;
    logic             cfg_done_q, cfg_done_d;
    logic             tbl_we;
    code_t            tbl_rdata;

    lut_table #(.SEL_W(SEL_W)) u_lut (
        .clk     (clk),
        .clr_i   (reset),
        .we_i    (tbl_we),
        .waddr_i (idx_q[SEL_W-1:0]),
        .wdata_i (bus.cfg_data),
        .raddr_i (bus.s),
        .rdata_o (tbl_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            f_q        <= 1'b0;
            f_valid_q  <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            f_q        <= f_d;
            f_valid_q  <= f_valid_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    // cfg_start outranks cfg_valid/in_valid in every state it is honoured
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        f_d        = f_q;
        f_valid_d  = 1'b0;
        cfg_done_d = 1'b0;
        tbl_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                if (bus.cfg_start) begin
                    idx_d = '0;
                end else if (bus.cfg_valid) begin
                    tbl_we = 1'b1;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d    = ST_RUN;
                        cfg_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end else if (bus.in_valid) begin
                    f_d       = decode(tbl_rdata, bus.d);
                    f_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.f        = f_q;
    assign bus.f_valid  = f_valid_q;
    assign bus.cfg_done = cfg_done_q;
    assign bus.busy     = (state_q == ST_LOAD);

endmodule

// File: tb/tb_prog_mux_fn.sv
// Self-checking bench for prog_mux_fn (SEL_W=3 main instance, SEL_W=2 secondary instance).
module tb_prog_mux_fn;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_mux_fn_if #(.SEL_W(3)) bus ();
    prog_mux_fn_if #(.SEL_W(2)) bus2 ();

    prog_mux_fn #(.SEL_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
    prog_mux_fn #(.SEL_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int checks   = 0;
    int failures = 0;

    // reference state: table contents as the spec says they should be, next write slot, last f
    logic [1:0] m_tbl [8];
    int         m_idx;
    logic       m_f;

    typedef struct {
        logic [2:0] s;
        logic       d;
        logic       exp_f;
    } vec_t;

    function automatic logic ref_f(input logic [1:0] code, input logic dd);
        if (code == 2'd0) return 1'b0;
        if (code == 2'd1) return 1'b1;
        if (code == 2'd2) return dd;
        return !dd;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic with_valid, input logic [1:0] junk);
        bus.cfg_start = 1'b1;
        bus.cfg_valid = with_valid;
        bus.cfg_data  = junk;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        m_idx = 0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_done", 32'(bus.cfg_done), 32'd0);
        chk("start_fvalid", 32'(bus.f_valid), 32'd0);
    endtask

    task automatic write_entry(input logic [1:0] code);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = code;
        tick();
        bus.cfg_valid = 1'b0;
        m_tbl[m_idx] = code;
        chk("wr_done", 32'(bus.cfg_done), 32'(m_idx == 7));
        chk("wr_busy", 32'(bus.busy), 32'(m_idx != 7));
        m_idx++;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("gap_busy", 32'(bus.busy), 32'd1);
            chk("gap_done", 32'(bus.cfg_done), 32'd0);
            chk("gap_fvalid", 32'(bus.f_valid), 32'd0);
        end
    endtask

    task automatic apply(input logic [2:0] ss, input logic dd);
        bus.in_valid = 1'b1;
        bus.s        = ss;
        bus.d        = dd;
        tick();
        bus.in_valid = 1'b0;
        m_f = ref_f(m_tbl[ss], dd);
        chk("run_fvalid", 32'(bus.f_valid), 32'd1);
        chk("run_f", 32'(bus.f), 32'(m_f));
    endtask

    task automatic check_all_entries();
        for (int i = 0; i < 8; i++) begin
            apply(3'(i), 1'b0);
            apply(3'(i), 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [4];
        logic [1:0] codes [8];

        bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = 0;
        bus.s = 0; bus.d = 0; bus.in_valid = 0;
        bus2.cfg_start = 0; bus2.cfg_valid = 0; bus2.cfg_data = 0;
        bus2.s = 0; bus2.d = 0; bus2.in_valid = 0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 2'd0;
        m_idx = 0;
        m_f   = 1'b0;

        // reset state, in_valid ignored in IDLE
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_f", 32'(bus.f), 32'd0);
        chk("rst_fvalid", 32'(bus.f_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.cfg_done), 32'd0);
        bus.in_valid = 1'b1; bus.cfg_valid = 1'b1; bus.s = 3'd1;
        tick();
        bus.in_valid = 1'b0; bus.cfg_valid = 1'b0;
        chk("idle_fvalid", 32'(bus.f_valid), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // directed table: codes 00,00,01,01,01,00,01,11
        codes = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b11};
        start_load(1'b0, 2'b00);
        for (int i = 0; i < 8; i++) write_entry(codes[i]);
        tick();
        chk("done_once", 32'(bus.cfg_done), 32'd0);
        vecs[0] = '{s: 3'd7, d: 1'b0, exp_f: 1'b1};
        vecs[1] = '{s: 3'd7, d: 1'b1, exp_f: 1'b0};
        vecs[2] = '{s: 3'd2, d: 1'b0, exp_f: 1'b1};
        vecs[3] = '{s: 3'd5, d: 1'b1, exp_f: 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.s = vecs[i].s; bus.d = vecs[i].d;
            tick();
            bus.in_valid = 1'b0;
            chk("vec_fvalid", 32'(bus.f_valid), 32'd1);
            chk("vec_f", 32'(bus.f), 32'(vecs[i].exp_f));
            m_f = vecs[i].exp_f;
        end
        tick();
        chk("idle_run_fvalid", 32'(bus.f_valid), 32'd0);
        chk("hold_f", 32'(bus.f), 32'(m_f));

        // cfg_start in RUN discards same-cycle in_valid; load with a 3-cycle gap after entry 3
        bus.in_valid = 1'b1; bus.s = 3'd2;
        start_load(1'b0, 2'b00);
        bus.in_valid = 1'b0;
        chk("run_start_hold_f", 32'(bus.f), 32'(m_f));
        for (int i = 0; i < 8; i++) begin
            write_entry(2'($urandom_range(0, 3)));
            if (i == 3) gap(3);
        end
        tick();
        chk("gap_done_once", 32'(bus.cfg_done), 32'd0);

        // back-to-back: s=0..7, d toggling, no bubbles
        for (int i = 0; i < 8; i++) apply(3'(i), 1'(i % 2));

        // cfg_start + cfg_valid together: data ignored, idx restarts at 0
        start_load(1'b1, 2'b01);
        write_entry(2'b10);
        for (int i = 1; i < 8; i++) write_entry(2'b11);
        apply(3'd0, 1'b1);
        apply(3'd0, 1'b0);
        apply(3'd1, 1'b1);

        // restart mid-load: partial writes then full reload from entry 0
        start_load(1'b0, 2'b00);
        for (int i = 0; i < 3; i++) write_entry(2'($urandom_range(0, 3)));
        start_load(1'b0, 2'b00);
        for (int i = 0; i < 8; i++) write_entry(2'($urandom_range(0, 3)));
        check_all_entries();

        // reset after 4 entries: everything cleared, RUN needs a full reload
        start_load(1'b0, 2'b00);
        for (int i = 0; i < 4; i++) write_entry(2'b01);
        reset = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_start = 1'b1;
        tick();
        reset = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_start = 1'b0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 2'd0;
        m_f = 1'b0;
        chk("mid_rst_f", 32'(bus.f), 32'd0);
        chk("mid_rst_fvalid", 32'(bus.f_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.cfg_done), 32'd0);
        bus.in_valid = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_data = 2'b01;
        tick(); tick();
        bus.in_valid = 1'b0; bus.cfg_valid = 1'b0;
        chk("post_rst_fvalid", 32'(bus.f_valid), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        start_load(1'b0, 2'b00);
        for (int i = 0; i < 7; i++) write_entry(2'($urandom_range(0, 3)));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("load_ignores_in_valid", 32'(bus.f_valid), 32'd0);
        write_entry(2'($urandom_range(0, 3)));
        check_all_entries();

        // randomized run with occasional random reloads (random gaps)
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                start_load(1'b0, 2'b00);
                for (int i = 0; i < 8; i++) begin
                    if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
                    write_entry(2'($urandom_range(0, 3)));
                end
            end else begin
                logic iv;
                logic [2:0] ss;
                logic dd;
                iv = 1'($urandom_range(0, 1));
                ss = 3'($urandom_range(0, 7));
                dd = 1'($urandom_range(0, 1));
                bus.in_valid = iv; bus.s = ss; bus.d = dd;
                tick();
                bus.in_valid = 1'b0;
                if (iv) m_f = ref_f(m_tbl[ss], dd);
                chk("rnd_fvalid", 32'(bus.f_valid), 32'(iv));
                chk("rnd_f", 32'(bus.f), 32'(m_f));
            end
        end

        // SEL_W=2 instance: 4 entries, cfg_done after the 4th write
        codes[0] = 2'b11; codes[1] = 2'b01; codes[2] = 2'b00; codes[3] = 2'b10;
        bus2.cfg_start = 1'b1;
        tick();
        bus2.cfg_start = 1'b0;
        chk("s2_busy", 32'(bus2.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus2.cfg_valid = 1'b1; bus2.cfg_data = codes[i];
            tick();
            bus2.cfg_valid = 1'b0;
            chk("s2_done", 32'(bus2.cfg_done), 32'(i == 3));
        end
        chk("s2_busy_end", 32'(bus2.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            for (int dv = 0; dv < 2; dv++) begin
                bus2.in_valid = 1'b1; bus2.s = 2'(i); bus2.d = 1'(dv);
                tick();
                bus2.in_valid = 1'b0;
                chk("s2_fvalid", 32'(bus2.f_valid), 32'd1);
                chk("s2_f", 32'(bus2.f), 32'(ref_f(codes[i], 1'(dv))));
            end
        end
        bus2.in_valid = 1'b1; bus2.s = 2'd3; bus2.d = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        chk("s2_sel3", 32'(bus2.f), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
